// File: rtl/imem_access_ctrl.sv
// Owns the single byte-wide instruction memory port, arbitrating between 32-bit fetches (four byte reads, big-endian)
// and single-byte loader writes. A fetch takes 6 cycles from grant to the next grant, a write takes 2.
module imem_access_ctrl #(
   parameter int ADDR_W          = 10,
   parameter bit LOADER_PRIORITY = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_valid,
   output logic              f_err,
   output logic [31:0]       f_instr,
   input  logic              l_req,
   input  logic [31:0]       l_addr,
   input  logic [7:0]        l_data,
   output logic              l_gnt,
   output logic              l_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   state_t            state_q;
   logic [1:0]        k_q;
   logic [23:0]       bytes_q;
   logic [31:0]       f_instr_q;
   logic [31:0]       f_word_d;
   logic              f_valid_q;
   logic              f_err_q;
   logic              l_err_q;
   logic              mem_we_q;
   logic              last_f_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;

   logic idle;
   logic tie_l;
   logic f_ok;
   logic l_ok;

   assign idle  = (state_q == IDLE) && !rst;
   assign tie_l = LOADER_PRIORITY ? 1'b1 : last_f_q;
   assign l_gnt = idle && l_req && (!f_req || tie_l);
   assign f_gnt = idle && f_req && !(l_req && tie_l);

   assign f_ok = (f_addr[1:0] == 2'b00) && (f_addr[31:ADDR_W] == '0);
   assign l_ok = (l_addr[31:ADDR_W] == '0);

   // The last byte arrives on mem_rdata in the CAP cycle itself, so the word is completed combinationally there.
   assign f_word_d = f_err_q ? 32'h0 : {bytes_q, mem_rdata};
   assign f_instr  = (state_q == CAP) ? f_word_d : f_instr_q;

   assign f_valid   = f_valid_q;
   assign f_err     = f_err_q;
   assign l_err     = l_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q & ~rst;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= 2'd0;
         bytes_q     <= 24'h0;
         f_instr_q   <= 32'h0;
         f_valid_q   <= 1'b0;
         f_err_q     <= 1'b0;
         l_err_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         last_f_q    <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h0;
      end else begin
         f_valid_q <= 1'b0;
         f_err_q   <= 1'b0;
         l_err_q   <= 1'b0;
         mem_we_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (l_gnt) begin
                  last_f_q <= 1'b0;
                  state_q  <= WR;
                  if (l_ok) begin
                     mem_addr_q  <= l_addr[ADDR_W-1:0];
                     mem_wdata_q <= l_data;
                     mem_we_q    <= 1'b1;
                  end else begin
                     l_err_q <= 1'b1;
                  end
               end else if (f_gnt) begin
                  last_f_q <= 1'b1;
                  if (f_ok) begin
                     state_q    <= RD;
                     k_q        <= 2'd0;
                     mem_addr_q <= f_addr[ADDR_W-1:0];
                  end else begin
                     state_q   <= CAP;
                     f_valid_q <= 1'b1;
                     f_err_q   <= 1'b1;
                  end
               end
            end
            RD: begin
               // Byte k-1 is on mem_rdata while address k is being presented.
               if (k_q != 2'd0) begin
                  bytes_q <= {bytes_q[15:0], mem_rdata};
               end
               if (k_q == 2'd3) begin
                  state_q   <= CAP;
                  f_valid_q <= 1'b1;
               end else begin
                  k_q        <= k_q + 2'd1;
                  mem_addr_q <= mem_addr_q + ADDR_W'(1);
               end
            end
            CAP: begin
               f_instr_q <= f_word_d;
               state_q   <= IDLE;
            end
            WR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Cycle-by-cycle vector table for the loader-priority instance, plus a round-robin sequence on a second instance.
module tb_imem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        f_req, l_req;
   logic [31:0] f_addr, l_addr;
   logic [7:0]  l_data;
   logic        f_gnt, f_valid, f_err, l_gnt, l_err, mem_we, busy;
   logic [31:0] f_instr;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   logic        f_req2, l_req2;
   logic [31:0] f_addr2, l_addr2;
   logic [7:0]  l_data2;
   logic        f_gnt2, f_valid2, f_err2, l_gnt2, l_err2, mem_we2, busy2;
   logic [31:0] f_instr2;
   logic [9:0]  mem_addr2;
   logic [7:0]  mem_wdata2, mem_rdata2;

   imem_access_ctrl #(.ADDR_W(10), .LOADER_PRIORITY(1'b1)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_err(f_err), .f_instr(f_instr),
      .l_req(l_req), .l_addr(l_addr), .l_data(l_data), .l_gnt(l_gnt), .l_err(l_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   imem_access_ctrl #(.ADDR_W(10), .LOADER_PRIORITY(1'b0)) dut_rr (
      .clk(clk), .rst(rst),
      .f_req(f_req2), .f_addr(f_addr2), .f_gnt(f_gnt2), .f_valid(f_valid2), .f_err(f_err2), .f_instr(f_instr2),
      .l_req(l_req2), .l_addr(l_addr2), .l_data(l_data2), .l_gnt(l_gnt2), .l_err(l_err2),
      .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2)
   );

   // Synchronous-read byte memory with a bench-side preload port.
   logic [7:0] mem [0:1023];
   logic       pl_en;
   logic [9:0] pl_addr;
   logic [7:0] pl_dat;
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   function automatic logic [7:0] init_byte(input int a);
      case (a)
         'h10:    return 8'h8C;
         'h11:    return 8'h22;
         'h12:    return 8'h00;
         'h13:    return 8'h04;
         'h3FC:   return 8'h11;
         'h3FD:   return 8'h22;
         'h3FE:   return 8'h33;
         default: return 8'h00;
      endcase
   endfunction

   typedef struct packed {
      logic        f_gnt;
      logic        f_valid;
      logic        f_err;
      logic [31:0] f_instr;
      logic        l_gnt;
      logic        l_err;
      logic [9:0]  mem_addr;
      logic        mem_we;
      logic [7:0]  mem_wdata;
      logic        busy;
   } out_t;

   typedef struct {
      logic        rst;
      logic        f_req;
      logic [31:0] f_addr;
      logic        l_req;
      logic [31:0] l_addr;
      logic [7:0]  l_data;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic v(input logic [31:0] r, fq, fa, lq, la, ld, fg, fv, fe, fi, lg, le, ma, mw, md, bz);
      vec_t t;
      t.rst    = r[0];
      t.f_req  = fq[0];
      t.f_addr = fa;
      t.l_req  = lq[0];
      t.l_addr = la;
      t.l_data = ld[7:0];
      t.exp    = '{fg[0], fv[0], fe[0], fi, lg[0], le[0], ma[9:0], mw[0], md[7:0], bz[0]};
      vecs.push_back(t);
   endtask

   task automatic check_out(input int idx, input out_t a, input out_t e);
      n_checks++;
      if (a === e) n_pass++;
      else
         $display("FAIL row%0d: got fgnt=%b fval=%b ferr=%b instr=%h lgnt=%b lerr=%b maddr=%h we=%b wdata=%h busy=%b, expected fgnt=%b fval=%b ferr=%b instr=%h lgnt=%b lerr=%b maddr=%h we=%b wdata=%h busy=%b",
                  idx, a.f_gnt, a.f_valid, a.f_err, a.f_instr, a.l_gnt, a.l_err, a.mem_addr, a.mem_we, a.mem_wdata, a.busy,
                  e.f_gnt, e.f_valid, e.f_err, e.f_instr, e.l_gnt, e.l_err, e.mem_addr, e.mem_we, e.mem_wdata, e.busy);
   endtask

   localparam logic [31:0] H = 32'h8C220004;
   localparam logic [31:0] W = 32'h112233A5;
   localparam logic [31:0] G = 32'h5A3C0000;

   logic [4:0] exp_rr [8];
   out_t       act;
   logic [4:0] act_rr;

   initial begin
      rst = 1'b1; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_addr = '0; l_data = '0;
      f_req2 = 1'b0; f_addr2 = '0; l_req2 = 1'b0; l_addr2 = '0; l_data2 = '0; mem_rdata2 = 8'h00;
      pl_en = 1'b1; pl_addr = '0; pl_dat = '0;

      //  rst fq faddr   lq laddr   ldata | fg fv fe instr lg le maddr  we wdata busy
      v(1, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 0,     0, 0,     0);  // reset state
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 0,     0, 0,     0);
      v(0, 1, 'h10,   0, 0,      0,      1, 0, 0, 0, 0, 0, 0,     0, 0,     0);  // aligned fetch
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h10,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h11,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h12,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h13,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, H, 0, 0, 'h13,  0, 0,     1);
      v(0, 1, 'h12,   0, 0,      0,      1, 0, 0, H, 0, 0, 'h13,  0, 0,     0);  // misaligned
      v(0, 0, 0,      0, 0,      0,      0, 1, 1, 0, 0, 0, 'h13,  0, 0,     1);
      v(0, 1, 'h400,  0, 0,      0,      1, 0, 0, 0, 0, 0, 'h13,  0, 0,     0);  // out of range
      v(0, 0, 0,      0, 0,      0,      0, 1, 1, 0, 0, 0, 'h13,  0, 0,     1);
      v(0, 0, 0,      1, 'h3FF,  'hA5,   0, 0, 0, 0, 1, 0, 'h13,  0, 0,     0);  // write top byte
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h3FF, 1, 'hA5,  1);
      v(0, 1, 'h3FC,  0, 0,      0,      1, 0, 0, 0, 0, 0, 'h3FF, 0, 'hA5,  0);  // fetch top word
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h3FC, 0, 'hA5,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h3FD, 0, 'hA5,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h3FE, 0, 'hA5,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h3FF, 0, 'hA5,  1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, W, 0, 0, 'h3FF, 0, 'hA5,  1);
      v(0, 0, 0,      1, 'h400,  'h77,   0, 0, 0, W, 1, 0, 'h3FF, 0, 'hA5,  0);  // loader out of range
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, W, 0, 1, 'h3FF, 0, 'hA5,  1);
      v(0, 1, 'h10,   1, 'h20,   'h5A,   0, 0, 0, W, 1, 0, 'h3FF, 0, 'hA5,  0);  // tie: loader first
      v(0, 1, 'h10,   0, 0,      0,      0, 0, 0, W, 0, 0, 'h20,  1, 'h5A,  1);
      v(0, 1, 'h10,   0, 0,      0,      1, 0, 0, W, 0, 0, 'h20,  0, 'h5A,  0);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, W, 0, 0, 'h10,  0, 'h5A,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, W, 0, 0, 'h11,  0, 'h5A,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, W, 0, 0, 'h12,  0, 'h5A,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, W, 0, 0, 'h13,  0, 'h5A,  1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, H, 0, 0, 'h13,  0, 'h5A,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h13,  0, 'h5A,  0);
      v(0, 0, 0,      1, 'h21,   'h3C,   0, 0, 0, H, 1, 0, 'h13,  0, 'h5A,  0);  // fetch waits on write
      v(0, 1, 'h3FC,  0, 0,      0,      0, 0, 0, H, 0, 0, 'h21,  1, 'h3C,  1);
      v(0, 1, 'h10,   0, 0,      0,      1, 0, 0, H, 0, 0, 'h21,  0, 'h3C,  0);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h10,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h11,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h12,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h13,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, H, 0, 0, 'h13,  0, 'h3C,  1);
      v(0, 1, 'h10,   0, 0,      0,      1, 0, 0, H, 0, 0, 'h13,  0, 'h3C,  0);  // reset mid-fetch
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h10,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h11,  0, 'h3C,  1);
      v(1, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h12,  0, 'h3C,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 0,     0, 0,     0);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 0,     0, 0,     0);
      v(0, 0, 0,      1, 'h10,   'hFF,   0, 0, 0, 0, 1, 0, 0,     0, 0,     0);  // reset during write
      v(1, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h10,  0, 'hFF,  1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 0,     0, 0,     0);
      v(0, 1, 'h10,   0, 0,      0,      1, 0, 0, 0, 0, 0, 0,     0, 0,     0);  // byte 0x10 unchanged
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h10,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h11,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h12,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, 0, 0, 0, 'h13,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, H, 0, 0, 'h13,  0, 0,     1);
      v(0, 1, 'h20,   0, 0,      0,      1, 0, 0, H, 0, 0, 'h13,  0, 0,     0);  // bytes written earlier
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h20,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h21,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h22,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 0, 0, H, 0, 0, 'h23,  0, 0,     1);
      v(0, 0, 0,      0, 0,      0,      0, 1, 0, G, 0, 0, 'h23,  0, 0,     1);

      // {l_gnt, f_gnt, l_err, f_valid, f_err} per cycle with both requests held on the round-robin instance.
      exp_rr = '{5'b10000, 5'b00100, 5'b01000, 5'b00011, 5'b10000, 5'b00100, 5'b01000, 5'b00011};

      for (int i = 0; i < 1024; i++) begin
         pl_addr = i[9:0];
         pl_dat  = init_byte(i);
         @(posedge clk); #1;
      end
      pl_en = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         rst    = vecs[i].rst;
         f_req  = vecs[i].f_req;
         f_addr = vecs[i].f_addr;
         l_req  = vecs[i].l_req;
         l_addr = vecs[i].l_addr;
         l_data = vecs[i].l_data;
         @(negedge clk);
         act = '{f_gnt, f_valid, f_err, f_instr, l_gnt, l_err, mem_addr, mem_we, mem_wdata, busy};
         check_out(i, act, vecs[i].exp);
      end

      @(posedge clk); #1;
      f_req = 1'b0; l_req = 1'b0;
      f_req2 = 1'b1; f_addr2 = 32'h12; l_req2 = 1'b1; l_addr2 = 32'h400; l_data2 = 8'h00;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         act_rr = {l_gnt2, f_gnt2, l_err2, f_valid2, f_err2};
         n_checks++;
         if (act_rr === exp_rr[c]) n_pass++;
         else $display("FAIL rr_cycle%0d: got lgnt,fgnt,lerr,fval,ferr=%b expected %b", c, act_rr, exp_rr[c]);
         @(posedge clk); #1;
      end
      f_req2 = 1'b0; l_req2 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences and arbitrates a single-byte-port, byte-addressed instruction memory (1024 x 8, synchronous read) between two requesters.
- Fetch requester: the PC/fetch stage, which needs 32-bit words.
- Loader requester: the program-load/debug path, which writes single bytes.
- A fetch is assembled from four sequential byte reads, big-endian (byte at base address lands in [31:24]).
- Replaces the direct 4-byte parallel lookup with a real port owner.

Parameters:
- ADDR_W, 10, memory byte-address width (depth = 2^ADDR_W).
- LOADER_PRIORITY, 1, tie-break mode. 1 = loader always wins a simultaneous request; 0 = alternate (round-robin).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  32  fetch byte address, sampled on grant
- f_gnt  out  1  one-cycle fetch accept pulse
- f_valid  out  1  one-cycle fetch completion pulse
- f_err  out  1  qualifies f_valid: misaligned or out-of-range address
- f_instr  out  32  fetched word, valid with f_valid
- l_req  in  1  loader write request, held until l_gnt
- l_addr  in  32  loader byte address, sampled on grant
- l_data  in  8  loader write byte, sampled on grant
- l_gnt  out  1  one-cycle loader accept pulse
- l_err  out  1  one-cycle pulse: loader address out of range, write dropped
- mem_addr  out  ADDR_W  memory byte address
- mem_we  out  1  memory write enable
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  read data, valid the cycle after mem_addr is presented with mem_we=0
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - all pulses and mem_we, busy = 0
  - f_instr = 0, mem_addr = 0, mem_wdata = 0
  - FSM = IDLE
  - round-robin pointer = "fetch last served", so the first tie goes to the loader
- States: IDLE, RD (4 issue cycles, byte counter k=0..3), CAP, WR.
- Grants are made only in IDLE; a request arriving while busy waits. Grant cycle = T. f_gnt/l_gnt are combinational from IDLE and the requests.
- Tie (both requests high in IDLE):
  - LOADER_PRIORITY=1: loader wins.
  - LOADER_PRIORITY=0: the requester not served last wins; the pointer updates on every grant.
- Fetch, in range and aligned (f_addr[1:0]==0, f_addr[31:ADDR_W]==0):
  - T+1..T+4: RD, mem_addr = base+k, mem_we=0.
  - Bytes are captured from mem_rdata at T+2..T+5.
  - T+5: CAP, f_valid=1, f_err=0, f_instr = {b0,b1,b2,b3}.
  - T+6: IDLE, new grant possible.
  - base+3 never wraps: alignment guarantees it stays in range.
- Fetch error (misaligned or out of range):
  - No memory access.
  - T+1: f_valid=1, f_err=1, f_instr=0.
  - T+2: IDLE.
- f_instr holds its value until the next f_valid.
- f_req dropping after grant has no effect; the fetch completes.
- Loader write:
  - T+1: WR, mem_addr = l_addr[ADDR_W-1:0], mem_wdata = l_data, mem_we=1.
  - T+2: IDLE.
  - Out of range: WR still occupies T+1 with mem_we=0 and l_err=1.
- mem_we is gated as registered_we & ~rst, so rst high during a WR cycle suppresses that write.
- Reset mid-operation:
  - Any state returns to IDLE next edge.
  - An in-flight fetch is discarded with no f_valid.
  - Captured bytes are cleared.
- Outside RD/WR: mem_we=0 and mem_addr holds its last value.
- Throughput: fetch = 1 word per 6 cycles; write = 1 byte per 2 cycles.

Test Plan:
- Preload bytes 0x10..0x13 = 8C,22,00,04; f_req with f_addr=0x10 in IDLE -> f_gnt at T, mem_addr 0x10..0x13 at T+1..T+4, f_valid at T+5 with f_instr=0x8C220004, f_err=0, busy T+1..T+5.
- f_addr=0x12 (misaligned), then f_addr=0x400 (out of range) -> each yields f_valid+f_err at T+1, f_instr=0, mem_addr never driven to a new value.
- l_req l_addr=0x3FF l_data=0xA5, then fetch 0x3FC -> mem_we=1 only at T+1 with mem_addr=0x3FF; fetched word [7:0]=0xA5. Then l_addr=0x400 -> l_err pulse, mem_we stays 0.
- Simultaneous f_req/l_req, held, LOADER_PRIORITY=1 -> loader granted first, fetch granted 2 cycles later. LOADER_PRIORITY=0 with both held continuously -> grants alternate L,F,L,F.
- rst asserted at T+3 of a fetch -> no f_valid, IDLE next cycle, all outputs 0. rst asserted during WR cycle -> mem_we=0 that cycle, memory byte unchanged.
- f_req asserted while busy with a write -> no f_gnt until IDLE, then granted same cycle IDLE is reached, with f_addr sampled then.
